// File: rtl/fpu_defs_fmac_pkg.sv
// Shared fmac datapath definitions: default mantissa widths and the Booth
// multiplier state type.
package fpu_defs_fmac;

  localparam int unsigned C_MANT_FP32 = 24;
  localparam int unsigned C_BOOTH_W   = C_MANT_FP32;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } booth_state_t;

endpackage

// File: rtl/booth_iter_mult_csa.sv
// 3:2 carry-save compressor; o_carry is unshifted (weight 2 per bit position).
module CSA #(
  parameter int unsigned n = 8
) (
  input  logic [n-1:0] i_a,
  input  logic [n-1:0] i_b,
  input  logic [n-1:0] i_c,
  output logic [n-1:0] o_sum,
  output logic [n-1:0] o_carry
);

  assign o_sum   = i_a ^ i_b ^ i_c;
  assign o_carry = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/booth_iter_mult.sv
// Iterative radix-4 Booth multiplier: one partial product per cycle folded into a
// carry-save pair, resolved by a final carry-propagate add.
module booth_iter_mult
  import fpu_defs_fmac::*;
#(
  parameter int unsigned WIDTH = C_BOOTH_W
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RBI,
  input  logic                 Flush_SI,
  input  logic                 In_Valid_SI,
  output logic                 In_Ready_SO,
  input  logic [WIDTH-1:0]     OpA_DI,
  input  logic [WIDTH-1:0]     OpB_DI,
  output logic                 Out_Valid_SO,
  input  logic                 Out_Ready_SI,
  output logic [2*WIDTH-1:0]   Prod_DO,
  output logic                 Busy_SO
);

  localparam int unsigned NPP  = WIDTH / 2 + 1;
  localparam int unsigned CSW  = 2 * WIDTH + 2;
  localparam int unsigned CNTW = $clog2(NPP);
  localparam int unsigned BXW  = 2 * NPP + 1;
  localparam logic [CNTW-1:0] C_LAST = CNTW'(NPP - 1);

  booth_state_t r_state, w_state_nxt;

  logic [CNTW-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_opa, r_opb;
  logic [CSW-1:0]     r_sum, r_carry;
  logic [2*WIDTH-1:0] r_prod;

  logic               w_last;
  logic [BXW-1:0]     w_bext;
  logic [2:0]         w_trip;
  logic [CSW-1:0]     w_a_ext, w_pp_unsh, w_pp, w_carry_sh;
  logic [CSW-1:0]     w_csa_sum, w_csa_carry, w_cpa;
  logic               w_unused;

  assign w_last = (r_cnt == C_LAST);

  // Multiplier padded with B[-1]=0 below and zeros above so every digit window is in range.
  assign w_bext = {{(BXW - WIDTH - 1){1'b0}}, r_opb, 1'b0};
  assign w_trip = w_bext[{r_cnt, 1'b0} +: 3];

  assign w_a_ext = CSW'(r_opa);

  always_comb begin
    w_pp_unsh = '0;
    case (w_trip)
      3'b001, 3'b010: w_pp_unsh = w_a_ext;
      3'b011:         w_pp_unsh = w_a_ext << 1;
      3'b100:         w_pp_unsh = -(w_a_ext << 1);
      3'b101, 3'b110: w_pp_unsh = -w_a_ext;
      default:        w_pp_unsh = '0;
    endcase
  end

  assign w_pp       = w_pp_unsh << {r_cnt, 1'b0};
  assign w_carry_sh = r_carry << 1;

  CSA #(.n(CSW)) u_csa (
    .i_a     (r_sum),
    .i_b     (w_carry_sh),
    .i_c     (w_pp),
    .o_sum   (w_csa_sum),
    .o_carry (w_csa_carry)
  );

  assign w_cpa = w_csa_sum + (w_csa_carry << 1);

  // Bits above 2*WIDTH only absorb two's-complement wrap of negative digits.
  assign w_unused = ^{w_cpa[CSW-1:2*WIDTH], r_carry[CSW-1]};

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (In_Valid_SI)  w_state_nxt = ITER;
      ITER:    if (w_last)       w_state_nxt = DONE;
      DONE:    if (Out_Ready_SI) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (Flush_SI) begin
      w_state_nxt = IDLE;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_cnt   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_sum   <= '0;
      r_carry <= '0;
      r_prod  <= '0;
    end else if (Flush_SI) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (In_Valid_SI) begin
            r_opa   <= OpA_DI;
            r_opb   <= OpB_DI;
            r_sum   <= '0;
            r_carry <= '0;
            r_cnt   <= '0;
          end
        end
        ITER: begin
          r_sum   <= w_csa_sum;
          r_carry <= w_csa_carry;
          r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
          if (w_last) begin
            r_prod <= w_cpa[2*WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign In_Ready_SO  = (r_state == IDLE);
  assign Out_Valid_SO = (r_state == DONE);
  assign Busy_SO      = (r_state != IDLE);
  assign Prod_DO      = r_prod;

endmodule

// File: tb/tb_booth_iter_mult.sv
// Self-checking bench for booth_iter_mult: directed corner cases plus random
// operands against a plain A*B reference, at widths 24, 11 and 53.
module tb_booth_iter_mult;

  localparam int unsigned W   = 24;
  localparam int unsigned NPP = W / 2 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  logic           rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]   opa, opb;
  logic [2*W-1:0] prod;

  logic        x_rst_n;
  logic        no_flush;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [10:0] a_opa, a_opb;
  logic [21:0] a_prod;
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
  logic [52:0] c_opa, c_opb;
  logic [105:0] c_prod;

  booth_iter_mult #(.WIDTH(W)) u_dut (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Flush_SI(flush),
    .In_Valid_SI(in_valid), .In_Ready_SO(in_ready),
    .OpA_DI(opa), .OpB_DI(opb),
    .Out_Valid_SO(out_valid), .Out_Ready_SI(out_ready),
    .Prod_DO(prod), .Busy_SO(busy)
  );

  booth_iter_mult #(.WIDTH(11)) u_dut11 (
    .Clk_CI(clk), .Rst_RBI(x_rst_n), .Flush_SI(no_flush),
    .In_Valid_SI(a_in_valid), .In_Ready_SO(a_in_ready),
    .OpA_DI(a_opa), .OpB_DI(a_opb),
    .Out_Valid_SO(a_out_valid), .Out_Ready_SI(a_out_ready),
    .Prod_DO(a_prod), .Busy_SO(a_busy)
  );

  booth_iter_mult #(.WIDTH(53)) u_dut53 (
    .Clk_CI(clk), .Rst_RBI(x_rst_n), .Flush_SI(no_flush),
    .In_Valid_SI(c_in_valid), .In_Ready_SO(c_in_ready),
    .OpA_DI(c_opa), .OpB_DI(c_opb),
    .Out_Valid_SO(c_out_valid), .Out_Ready_SI(c_out_ready),
    .Prod_DO(c_prod), .Busy_SO(c_busy)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the 24-bit DUT idle; returns at a negedge with it idle again.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int unsigned stall);
    int unsigned  lat;
    logic [127:0] exp;
    exp = 128'(a) * 128'(b);
    chk("rdy", 128'(in_ready), 128'(1));
    in_valid  = 1'b1;
    opa       = a;
    opb       = b;
    out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 4 * NPP) begin
      in_valid  = 1'($urandom_range(0, 1));
      opa       = W'($urandom);
      opb       = W'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 128'(lat), 128'(NPP));
    for (int i = 0; i < int'(stall); i++) begin
      out_ready = 1'b0;
      chk("prod_hold", 128'(prod), exp);
      chk("rdy_in_done", 128'(in_ready), 128'(0));
      chk("valid_hold", 128'(out_valid), 128'(1));
      @(negedge clk);
    end
    chk("prod", 128'(prod), exp);
    chk("valid", 128'(out_valid), 128'(1));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", 128'(out_valid), 128'(0));
    chk("rdy_idle", 128'(in_ready), 128'(1));
  endtask

  initial begin
    rst_n = 1'b0; x_rst_n = 1'b0; no_flush = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; opa = '0; opb = '0;
    a_in_valid = 1'b0; a_out_ready = 1'b0; a_opa = '0; a_opb = '0;
    c_in_valid = 1'b0; c_out_ready = 1'b0; c_opa = '0; c_opb = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_ready", 128'(in_ready), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_prod", 128'(prod), 128'(0));
    rst_n = 1'b1; x_rst_n = 1'b1;
    @(negedge clk);

    fork
      begin : main24
        int unsigned  seen;
        logic [W-1:0] ra, rb;

        do_op(24'h000001, 24'h000001, 0);
        chk("t1_prod", 128'(prod), 128'h000000000001);
        do_op(24'hFFFFFF, 24'hFFFFFF, 0);
        chk("t2_prod", 128'(prod), 128'hFFFFFE000001);
        do_op(24'h800000, 24'hAAAAAA, 5);
        chk("t3_prod", 128'(prod), 128'h555555000000);

        // Flush partway through an operation.
        in_valid = 1'b1; opa = 24'h123456; opb = 24'h654321;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", 128'(busy), 128'(0));
        chk("flush_ready", 128'(in_ready), 128'(1));
        chk("flush_valid", 128'(out_valid), 128'(0));
        seen = 0;
        repeat (2 * NPP) begin
          @(negedge clk);
          if (out_valid) seen++;
        end
        chk("flush_no_beat", 128'(seen), 128'(0));
        flush = 1'b1; in_valid = 1'b1; opa = 24'h000007; opb = 24'h000009;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle_block", 128'(busy), 128'(0));
        do_op(24'h000003, 24'h000005, 1);
        chk("t4_prod", 128'(prod), 128'd15);

        // Asynchronous reset mid-operation.
        in_valid = 1'b1; opa = 24'hABCDEF; opb = 24'h13579B;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(out_valid), 128'(0));
        chk("arst_ready", 128'(in_ready), 128'(1));
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_prod", 128'(prod), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(24'hC00000, 24'h000002, 0);
        chk("t5_prod", 128'(prod), 128'h000001800000);

        for (int n = 0; n < 2500; n++) begin
          case ($urandom_range(0, 7))
            0:       ra = '1;
            1:       ra = '0;
            2:       ra = W'(1) << $urandom_range(0, W - 1);
            default: ra = W'($urandom);
          endcase
          case ($urandom_range(0, 7))
            0:       rb = '1;
            1:       rb = '0;
            2:       rb = W'(24'hAAAAAA);
            default: rb = W'($urandom);
          endcase
          do_op(ra, rb, $urandom_range(0, 3));
        end
      end

      begin : rand11
        logic [10:0] a, b;
        int unsigned lat;
        for (int n = 0; n < 1500; n++) begin
          a = 11'($urandom);
          b = 11'($urandom);
          chk("w11_rdy", 128'(a_in_ready), 128'(1));
          a_in_valid = 1'b1; a_opa = a; a_opb = b;
          @(negedge clk);
          a_in_valid = 1'b0;
          lat = 0;
          while (!a_out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
          end
          chk("w11_latency", 128'(lat), 128'(6));
          repeat ($urandom_range(0, 2)) @(negedge clk);
          chk("w11_prod", 128'(a_prod), 128'(a) * 128'(b));
          a_out_ready = 1'b1;
          @(negedge clk);
          a_out_ready = 1'b0;
          chk("w11_busy", 128'(a_busy), 128'(0));
        end
      end

      begin : rand53
        logic [52:0] a, b;
        int unsigned lat;
        for (int n = 0; n < 800; n++) begin
          a = 53'({$urandom, $urandom});
          b = 53'({$urandom, $urandom});
          if (n == 0) begin
            a = '1;
            b = '1;
          end
          chk("w53_rdy", 128'(c_in_ready), 128'(1));
          c_in_valid = 1'b1; c_opa = a; c_opb = b;
          @(negedge clk);
          c_in_valid = 1'b0;
          lat = 0;
          while (!c_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
          end
          chk("w53_latency", 128'(lat), 128'(27));
          repeat ($urandom_range(0, 2)) @(negedge clk);
          chk("w53_prod", 128'(c_prod), 128'(a) * 128'(b));
          c_out_ready = 1'b1;
          @(negedge clk);
          c_out_ready = 1'b0;
          chk("w53_busy", 128'(c_busy), 128'(0));
        end
      end
    join

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
